// File: rtl/pc_redirect_ctrl.sv
// Execute-stage control-flow resolver: evaluates branches/jumps, issues PC redirect
// and flushes, traps misaligned targets, and keeps saturating branch/redirect counts.
module pc_redirect_ctrl #(
  parameter int PC_Width  = 32,
  parameter int CNT_Width = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid_E,
  input  logic                 i_Branch_E,
  input  logic                 i_Jump_E,
  input  logic                 i_Jal_R_E_req,
  input  logic [2:0]           i_funct3_E,
  input  logic                 i_Zero_E,
  input  logic                 i_Lt_E,
  input  logic                 i_Ltu_E,
  input  logic [PC_Width-1:0]  i_PC_target_E,
  input  logic                 i_trap_ack,
  output logic                 o_Jal_R_E,
  output logic                 o_PCSrc_E,
  output logic                 o_Flush_D,
  output logic                 o_Flush_E,
  output logic                 o_trap,
  output logic [PC_Width-1:0]  o_trap_PC,
  output logic [CNT_Width-1:0] o_branch_cnt,
  output logic [CNT_Width-1:0] o_redirect_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHADOW = 2'd1,
    TRAP   = 2'd2
  } state_t;

  localparam logic [CNT_Width-1:0] CNT_MAX = {CNT_Width{1'b1}};
  localparam logic [CNT_Width-1:0] CNT_ONE = {{(CNT_Width-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic                  trap_q, trap_d;
  logic [PC_Width-1:0]   trap_pc_q, trap_pc_d;
  logic [CNT_Width-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_Width-1:0]  redirect_cnt_q, redirect_cnt_d;

  logic taken;
  logic req;
  logic misaligned;

  always_comb begin
    taken = 1'b0;
    case (i_funct3_E)
      3'b000:  taken = i_Zero_E;
      3'b001:  taken = ~i_Zero_E;
      3'b100:  taken = i_Lt_E;
      3'b101:  taken = ~i_Lt_E;
      3'b110:  taken = i_Ltu_E;
      3'b111:  taken = ~i_Ltu_E;
      default: taken = 1'b0;
    endcase
  end

  assign req        = i_valid_E & (i_Jump_E | i_Jal_R_E_req | (i_Branch_E & taken));
  assign misaligned = i_PC_target_E[1];
  assign o_Jal_R_E  = i_Jal_R_E_req & i_valid_E;

  // Redirect/flush controls are zero-latency in IDLE, state-only in SHADOW and TRAP.
  always_comb begin
    state_d        = state_q;
    trap_d         = trap_q;
    trap_pc_d      = trap_pc_q;
    branch_cnt_d   = branch_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    o_PCSrc_E      = 1'b0;
    o_Flush_D      = 1'b0;
    o_Flush_E      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid_E && i_Branch_E && (branch_cnt_q != CNT_MAX)) begin
          branch_cnt_d = branch_cnt_q + CNT_ONE;
        end else begin
          branch_cnt_d = branch_cnt_q;
        end
        if (req) begin
          o_Flush_D = 1'b1;
          o_Flush_E = 1'b1;
          if (misaligned) begin
            trap_d    = 1'b1;
            trap_pc_d = i_PC_target_E;
            state_d   = TRAP;
          end else begin
            o_PCSrc_E = 1'b1;
            state_d   = SHADOW;
            if (redirect_cnt_q != CNT_MAX) begin
              redirect_cnt_d = redirect_cnt_q + CNT_ONE;
            end else begin
              redirect_cnt_d = redirect_cnt_q;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHADOW: begin
        o_Flush_E = 1'b1;
        state_d   = IDLE;
      end
      TRAP: begin
        o_Flush_D = 1'b1;
        o_Flush_E = 1'b1;
        if (i_trap_ack) begin
          trap_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = TRAP;
        end
      end
      default: begin
        state_d = IDLE;
        trap_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q        <= IDLE;
      trap_q         <= 1'b0;
      trap_pc_q      <= {PC_Width{1'b0}};
      branch_cnt_q   <= {CNT_Width{1'b0}};
      redirect_cnt_q <= {CNT_Width{1'b0}};
    end else begin
      state_q        <= state_d;
      trap_q         <= trap_d;
      trap_pc_q      <= trap_pc_d;
      branch_cnt_q   <= branch_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign o_trap         = trap_q;
  assign o_trap_PC      = trap_pc_q;
  assign o_branch_cnt   = branch_cnt_q;
  assign o_redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: the driver pushes the expected per-cycle
// outputs, a negedge monitor pops and compares them against the DUT.
module tb_pc_redirect_ctrl;

  localparam int PW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n, valid, branch, jump, jalr, zero, lt, ltu, ack;
  logic [2:0]    f3;
  logic [PW-1:0] target;
  logic          jal_r_o, pcsrc_o, flush_d_o, flush_e_o, trap_o;
  logic [PW-1:0] trap_pc_o;
  logic [CW-1:0] bcnt_o, rcnt_o;

  typedef struct packed {
    logic          jal_r;
    logic          pcsrc;
    logic          fd;
    logic          fe;
    logic          trap;
    logic [PW-1:0] trap_pc;
    logic [CW-1:0] bcnt;
    logic [CW-1:0] rcnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // model state, written from the behavioural description
  int            m_state = 0; // 0 idle, 1 shadow, 2 trap
  logic          m_trap  = 1'b0;
  logic [PW-1:0] m_tpc   = '0;
  logic [CW-1:0] m_bcnt  = '0;
  logic [CW-1:0] m_rcnt  = '0;

  pc_redirect_ctrl #(.PC_Width(PW), .CNT_Width(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid_E(valid), .i_Branch_E(branch),
    .i_Jump_E(jump), .i_Jal_R_E_req(jalr), .i_funct3_E(f3), .i_Zero_E(zero),
    .i_Lt_E(lt), .i_Ltu_E(ltu), .i_PC_target_E(target), .i_trap_ack(ack),
    .o_Jal_R_E(jal_r_o), .o_PCSrc_E(pcsrc_o), .o_Flush_D(flush_d_o),
    .o_Flush_E(flush_e_o), .o_trap(trap_o), .o_trap_PC(trap_pc_o),
    .o_branch_cnt(bcnt_o), .o_redirect_cnt(rcnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // monitor: one expected record per cycle, compared mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("jal_r",   {31'd0, jal_r_o},   {31'd0, e.jal_r});
      chk("pcsrc",   {31'd0, pcsrc_o},   {31'd0, e.pcsrc});
      chk("flush_d", {31'd0, flush_d_o}, {31'd0, e.fd});
      chk("flush_e", {31'd0, flush_e_o}, {31'd0, e.fe});
      chk("trap",    {31'd0, trap_o},    {31'd0, e.trap});
      chk("trap_pc", trap_pc_o,          e.trap_pc);
      chk("bcnt",    {16'd0, bcnt_o},    {16'd0, e.bcnt});
      chk("rcnt",    {16'd0, rcnt_o},    {16'd0, e.rcnt});
    end
  end

  task automatic step(input logic r, input logic v, input logic b, input logic j,
                      input logic jr, input logic [2:0] fc, input logic z, input logic l,
                      input logic lu, input logic [PW-1:0] t, input logic a);
    exp_t e;
    logic tk, rq, mis;
    @(posedge clk);
    #1;
    rst_n = r; valid = v; branch = b; jump = j; jalr = jr; f3 = fc;
    zero = z; lt = l; ltu = lu; target = t; ack = a;
    case (fc)
      3'b000: tk = z;
      3'b001: tk = !z;
      3'b100: tk = l;
      3'b101: tk = !l;
      3'b110: tk = lu;
      3'b111: tk = !lu;
      default: tk = 1'b0;
    endcase
    rq  = v && (j || jr || (b && tk));
    mis = t[1];
    e = '0;
    e.jal_r = jr && v;
    e.trap = m_trap; e.trap_pc = m_tpc; e.bcnt = m_bcnt; e.rcnt = m_rcnt;
    if (m_state == 0) begin
      e.pcsrc = rq && !mis; e.fd = rq; e.fe = rq;
    end else if (m_state == 1) begin
      e.fe = 1'b1;
    end else begin
      e.fd = 1'b1; e.fe = 1'b1;
    end
    exp_q.push_back(e);
    if (!r) begin
      m_state = 0; m_trap = 1'b0; m_tpc = '0; m_bcnt = '0; m_rcnt = '0;
    end else if (m_state == 0) begin
      if (v && b && m_bcnt != 16'hFFFF) m_bcnt = m_bcnt + 16'd1;
      if (rq && mis) begin
        m_state = 2; m_trap = 1'b1; m_tpc = t;
      end else if (rq) begin
        m_state = 1;
        if (m_rcnt != 16'hFFFF) m_rcnt = m_rcnt + 16'd1;
      end
    end else if (m_state == 1) begin
      m_state = 0;
    end else if (ack) begin
      m_state = 0; m_trap = 1'b0;
    end
  endtask

  task automatic idle();                    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0); endtask
  task automatic br(input logic [2:0] fc, input logic z, input logic l, input logic lu, input logic [PW-1:0] t);
                                            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, fc, z, l, lu, t, 1'b0); endtask
  task automatic jal(input logic [PW-1:0] t);  step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, t, 1'b0); endtask
  task automatic jalr_i(input logic [PW-1:0] t); step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, t, 1'b0); endtask
  task automatic trap_ack();                step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1); endtask
  task automatic reset_cyc();               step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0); endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; branch = 1'b0; jump = 1'b0; jalr = 1'b0; f3 = 3'd0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0; target = '0; ack = 1'b0;
    @(posedge clk);
    reset_cyc(); idle();
    // BEQ taken, then shadow cycle
    br(3'b000, 1'b1, 1'b0, 1'b0, 32'h0000_0100); idle();
    // BLTU not taken
    br(3'b110, 1'b0, 1'b0, 1'b0, 32'h0000_0200); idle();
    // JALR misaligned: trap, held five cycles with a request that must be ignored
    jalr_i(32'h0000_0202);
    idle(); jal(32'h0000_0300); idle(); idle(); idle();
    trap_ack(); idle();
    // back-to-back JAL: second one falls into the shadow
    jal(32'h0000_0400); jal(32'h0000_0500); idle();
    // remaining conditions
    br(3'b001, 1'b0, 1'b0, 1'b0, 32'h0000_0600); idle();
    br(3'b001, 1'b1, 1'b0, 1'b0, 32'h0000_0600);
    br(3'b100, 1'b0, 1'b1, 1'b0, 32'h0000_0604); idle();
    br(3'b101, 1'b0, 1'b0, 1'b0, 32'h0000_0608); idle();
    br(3'b101, 1'b0, 1'b1, 1'b0, 32'h0000_0608);
    br(3'b111, 1'b0, 1'b0, 1'b0, 32'h0000_060C); idle();
    br(3'b010, 1'b1, 1'b1, 1'b1, 32'h0000_0610);
    br(3'b011, 1'b1, 1'b1, 1'b1, 32'h0000_0610);
    // bubble suppresses everything
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0000_0700, 1'b0);
    // branch not taken + jump: jump wins, branch counted
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0000_0800, 1'b0); idle();
    // JAL + JALR together behaves as JALR
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0000_0900, 1'b0); idle();
    // reset in the middle of SHADOW
    jal(32'h0000_0A00); reset_cyc(); idle();
    // rebuild counts, trap, then reset while trapped
    br(3'b000, 1'b1, 1'b0, 1'b0, 32'h0000_0B00); idle();
    jal(32'hFFFF_FFFE); idle(); idle();
    reset_cyc(); idle(); idle();
    // saturate the branch counter with not-taken branches, then one more
    for (int i = 0; i < 65535; i++) br(3'b010, 1'b0, 1'b0, 1'b0, 32'h0000_0C00);
    br(3'b010, 1'b0, 1'b0, 1'b0, 32'h0000_0C00);
    br(3'b000, 1'b1, 1'b0, 1'b0, 32'h0000_0D00); idle(); idle();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected records left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Control-flow resolution and redirect sequencer for the Execute stage. It evaluates branch conditions and jump requests, drives the JAL/JALR operand select into the PC-target adder, and issues the PC redirect plus pipeline flushes. It traps misaligned targets and holds the pipeline flushed until software/CSR logic acknowledges the trap. It also keeps saturating statistics counters; the fetch stage predicts not-taken, so every redirect counts as a mispredict.

Parameters:
PC_Width, 32, width of PC and target address
CNT_Width, 16, width of each statistics counter

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  synchronous active-low reset
i_valid_E  in  1  instruction in Execute is real (not a bubble)
i_Branch_E  in  1  conditional branch in Execute
i_Jump_E  in  1  JAL in Execute
i_Jal_R_E_req  in  1  JALR in Execute
i_funct3_E  in  3  branch condition code
i_Zero_E  in  1  ALU result zero (rs1 == rs2)
i_Lt_E  in  1  signed rs1 < rs2
i_Ltu_E  in  1  unsigned rs1 < rs2
i_PC_target_E  in  PC_Width  adder output (target address)
i_trap_ack  in  1  trap handler has consumed the trap
o_Jal_R_E  out  1  adder operand select: 1 = RS1, 0 = PC
o_PCSrc_E  out  1  fetch selects i_PC_target_E as next PC
o_Flush_D  out  1  clear the Decode pipeline register
o_Flush_E  out  1  clear the Execute pipeline register
o_trap  out  1  misaligned-target trap pending
o_trap_PC  out  PC_Width  offending target address
o_branch_cnt  out  CNT_Width  resolved conditional branches
o_redirect_cnt  out  CNT_Width  redirects taken

Behaviour:
- Reset (i_rst_n = 0 at a rising edge): state IDLE; o_trap = 0; o_trap_PC = 0; both counters = 0. Every output derived from state is 0 while the state is IDLE and no request is present.
- o_Jal_R_E = i_Jal_R_E_req & i_valid_E. This output is combinational.
- Condition evaluation (combinational) by i_funct3_E:
  - 000: taken = Zero
  - 001: taken = !Zero
  - 100: taken = Lt
  - 101: taken = !Lt
  - 110: taken = Ltu
  - 111: taken = !Ltu
  - 010, 011: taken = 0 (the branch is still counted)
- req = i_valid_E & (i_Jump_E | i_Jal_R_E_req | (i_Branch_E & taken)). This is evaluated only in IDLE.
- Misaligned = i_PC_target_E[1] (the target is formed as PC-target with bit0 cleared; no C extension).
- FSM states: IDLE, SHADOW, TRAP.
  - IDLE, req and not misaligned: o_PCSrc_E = 1, o_Flush_D = 1, o_Flush_E = 1 in the same cycle (combinational, zero latency). Next state is SHADOW.
  - IDLE, req and misaligned: o_PCSrc_E = 0. o_Flush_D and o_Flush_E = 1. Capture o_trap_PC = i_PC_target_E. Next state is TRAP.
  - IDLE, no req: all control outputs 0. Stay in IDLE.
  - SHADOW: lasts exactly 1 cycle. Inputs are ignored and o_PCSrc_E = 0. o_Flush_E = 1 so the wrong-path slot stays a bubble. Next state is IDLE.
  - TRAP: o_trap = 1. o_Flush_D and o_Flush_E = 1. o_PCSrc_E = 0. On i_trap_ack = 1, go to IDLE; o_trap clears on the same edge and o_trap_PC holds its value. Requests are ignored while in TRAP.
- Counters (registered, updated on the edge ending a cycle in IDLE):
  - o_branch_cnt increments when i_valid_E & i_Branch_E.
  - o_redirect_cnt increments on a non-misaligned req.
  - Both saturate at all-ones and never wrap.
- Priority: if i_Branch_E and a jump are both asserted, the jump wins and the branch counter still increments. If i_Jump_E and i_Jal_R_E_req are both asserted, the result is treated as JALR (o_Jal_R_E = 1).
- Reset mid-operation: a synchronous reset from SHADOW or TRAP returns to IDLE on that edge and clears o_trap, o_trap_PC and both counters.
- i_valid_E = 0 suppresses all evaluation; the FSM stays in IDLE.

Test Plan:
- BEQ: funct3 = 000, Zero = 1, target 0x0000_0100 -> PCSrc, Flush_D and Flush_E = 1 that cycle; the next cycle is SHADOW with PCSrc = 0 and Flush_E = 1; branch_cnt = 1, redirect_cnt = 1.
- BLTU not taken: funct3 = 110, Ltu = 0 -> no PCSrc, no flush; branch_cnt increments and redirect_cnt is unchanged.
- JALR with target 0x0000_0202 -> o_Jal_R_E = 1, trap asserted the next cycle, trap_PC = 0x0000_0202, flushes held for 5 cycles. Pulse trap_ack -> IDLE, trap = 0, redirect_cnt unchanged.
- Back-to-back JAL, then JAL the next cycle -> only the first redirects; the second is ignored in SHADOW; redirect_cnt = 1.
- Preload branch_cnt to 0xFFFF via 65 535 branches, then one more branch -> the count stays at 0xFFFF.
- Assert i_rst_n = 0 for one edge while in TRAP -> IDLE, trap = 0, trap_PC = 0, counters = 0.
